// File: rtl/heaa_pkg.sv
// heaa_pkg: shared definitions for the shared approximate-adder arbiter.
//   HEAA_W_DEFAULT / HEAA_INACC_DEFAULT : default operand and inaccurate-part widths
//   HEAA_NREQ_MAX / HEAA_IDW_MAX        : largest supported requester count and its ID width
//   heaa_rsp_t                          : response record {sum, id, approx} at default widths
//   rr_pick()                           : round-robin scan returning {idx, found}
package heaa_pkg;

  localparam int HEAA_W_DEFAULT     = 32;
  localparam int HEAA_INACC_DEFAULT = 10;
  localparam int HEAA_NREQ_MAX      = 8;
  localparam int HEAA_IDW_MAX       = 3;

  typedef struct packed {
    logic [HEAA_W_DEFAULT:0]  sum;
    logic [HEAA_IDW_MAX-1:0]  id;
    logic                     approx;
  } heaa_rsp_t;

  typedef struct packed {
    logic [HEAA_IDW_MAX-1:0] idx;
    logic                    found;
  } rr_pick_t;

  // First set bit of valid[n-1:0], scanning upward from ptr with wrap.
  // The scan runs from the farthest offset down to the nearest, so the
  // nearest hit is the one that survives; no early exit is needed.
  function automatic rr_pick_t rr_pick(input logic [HEAA_NREQ_MAX-1:0] valid,
                                       input logic [HEAA_IDW_MAX-1:0]  ptr,
                                       input int                       n);
    rr_pick_t r;
    int       i;
    r = '0;
    for (int k = HEAA_NREQ_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        i = (int'(ptr) + k) % n;
        if (valid[i]) begin
          r.idx   = HEAA_IDW_MAX'(i);
          r.found = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/heaa_add_arbiter_addn.sv
// heaa_addn: combinational exact/approximate adder.
//   a, b   : W-bit unsigned operands
//   approx : 1 = approximate (OR low part, XOR at INACC-1, AND carry), 0 = exact
//   sum    : W+1-bit result
module heaa_addn #(
  parameter int W     = 32,
  parameter int INACC = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         approx,
  output logic [W:0]   sum
);

  logic [INACC-1:0] lo;
  logic [W-INACC:0] hi;
  logic             cy;

  always_comb begin
    lo = '0;
    for (int k = 0; k < INACC - 1; k++) begin
      lo[k] = a[k] | b[k];
    end
    lo[INACC-1] = a[INACC-1] ^ b[INACC-1];
    // The only carry into the exact upper part is generated at bit INACC-1.
    cy = a[INACC-1] & b[INACC-1];
    hi = {1'b0, a[W-1:INACC]} + {1'b0, b[W-1:INACC]} + (W-INACC+1)'(cy);
    if (approx) sum = {hi, lo};
    else        sum = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/heaa_add_arbiter.sv
// heaa_add_arbiter: round-robin sharing of one exact/approximate adder.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b            : packed operands, requester i at [i*W +: W]
//   req_approx              : per-request mode bit
//   rsp_valid/rsp_ready     : single-slot registered response handshake
//   rsp_sum, rsp_id         : W+1-bit result and originating requester
//   rsp_approx              : mode bit used for this result
//   busy                    : mirrors rsp_valid
module heaa_add_arbiter
  import heaa_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = HEAA_W_DEFAULT,
  parameter int INACC = HEAA_INACC_DEFAULT,
  parameter int IDW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_approx,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_approx,
  output logic              busy
);

  logic [IDW-1:0] rr_ptr;
  rr_pick_t       pick;
  logic [IDW-1:0] gnt_id;
  logic           can_accept;
  logic           xfer;
  logic [W-1:0]   a_g;
  logic [W-1:0]   b_g;
  logic           apx_g;
  logic [W:0]     sum_g;

  logic           vld_p0;
  logic [W:0]     sum_p0;
  logic [IDW-1:0] id_p0;
  logic           apx_p0;

  always_comb begin
    can_accept = !vld_p0 || rsp_ready;
    pick       = rr_pick(HEAA_NREQ_MAX'(req_valid), HEAA_IDW_MAX'(rr_ptr), NREQ);
    gnt_id     = IDW'(pick.idx);
    // Gated by rst_n so no requester sees an accept while reset is held.
    xfer       = can_accept && pick.found && rst_n;
    req_ready  = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
    a_g   = req_a[int'(gnt_id)*W +: W];
    b_g   = req_b[int'(gnt_id)*W +: W];
    apx_g = req_approx[gnt_id];
  end

  heaa_addn #(.W(W), .INACC(INACC)) u_addn (
    .a      (a_g),
    .b      (b_g),
    .approx (apx_g),
    .sum    (sum_g)
  );

  // Stage p0: single output slot, overwritten on a transfer, cleared on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      sum_p0 <= '0;
      id_p0  <= '0;
      apx_p0 <= 1'b0;
      rr_ptr <= '0;
    end else if (xfer) begin
      vld_p0 <= 1'b1;
      sum_p0 <= sum_g;
      id_p0  <= gnt_id;
      apx_p0 <= apx_g;
      rr_ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
    end else if (rsp_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign rsp_valid  = vld_p0;
  assign rsp_sum    = sum_p0;
  assign rsp_id     = id_p0;
  assign rsp_approx = apx_p0;
  assign busy       = vld_p0;

endmodule

// File: tb/tb_heaa_add_arbiter.sv
module tb_heaa_add_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 32;
  localparam int INACC = 10;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_approx;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_approx;
  logic              busy;

  heaa_add_arbiter #(.NREQ(NREQ), .W(W), .INACC(INACC), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_approx (req_approx),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_id     (rsp_id),
    .rsp_approx (rsp_approx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;

  // Reference model state
  bit          m_vld = 0;
  logic [W:0]  m_sum = '0;
  int          m_id  = 0;
  bit          m_apx = 0;
  int          m_ptr = 0;

  function automatic logic [W:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, bit apx);
    logic [63:0] ua, ub, lo, mid, cy, hi;
    ua = 64'(a);
    ub = 64'(b);
    if (!apx) return (W+1)'(ua + ub);
    lo  = (ua | ub) & ((64'd1 << (INACC - 1)) - 64'd1);
    mid = ((ua ^ ub) >> (INACC - 1)) & 64'd1;
    cy  = ((ua & ub) >> (INACC - 1)) & 64'd1;
    hi  = (ua >> INACC) + (ub >> INACC) + cy;
    return (W+1)'((hi << INACC) | (mid << (INACC - 1)) | lo);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, bit apx);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_approx[i]   = apx;
  endtask

  task automatic model_reset();
    m_vld = 0; m_sum = '0; m_id = 0; m_apx = 0; m_ptr = 0;
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".valid"},  64'(rsp_valid),  64'(m_vld));
    chk({tag, ".sum"},    64'(rsp_sum),    64'(m_sum));
    chk({tag, ".id"},     64'(rsp_id),     64'(m_id));
    chk({tag, ".approx"}, 64'(rsp_approx), 64'(m_apx));
    chk({tag, ".busy"},   64'(busy),       64'(m_vld));
  endtask

  // Called just after a rising edge with inputs already applied; checks the
  // combinational grant, advances one clock, then checks the response slot.
  task automatic step(string tag);
    logic [NREQ-1:0] er;
    bit              gf;
    int              g;
    int              p;
    logic [W-1:0]    a, b;
    bit              apx;
    #1;
    er = '0; gf = 0; g = 0;
    if (!m_vld || rsp_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        p = (m_ptr + k) % NREQ;
        if (!gf && req_valid[p]) begin gf = 1; g = p; end
      end
    end
    if (gf) er[g] = 1'b1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(er));
    a   = req_a[g*W +: W];
    b   = req_b[g*W +: W];
    apx = req_approx[g];
    @(posedge clk); #1;
    if (gf) begin
      m_vld = 1; m_sum = ref_add(a, b, apx); m_id = g; m_apx = apx;
      m_ptr = (g + 1) % NREQ;
    end else if (rsp_ready) begin
      m_vld = 0;
    end
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_approx = '0; rsp_ready = 1'b1;

    // Reset state: outputs zero, no accept even with requests pending
    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    #1 chk("rst.ready", 64'(req_ready), 64'd0);
    check_outputs("rst");
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Req0 approx / exact around the INACC boundary
    set_req(0, 32'h0000_03FF, 32'h0000_0001, 1); req_valid = 4'b0001;
    step("r0apx");
    chk("r0apx.sum_const", 64'(rsp_sum), 64'h3FF);
    set_req(0, 32'h0000_03FF, 32'h0000_0001, 0);
    step("r0exact");
    chk("r0exact.sum_const", 64'(rsp_sum), 64'h400);

    // Req1 carry out of the approximate part, and full-width exact overflow
    req_valid = 4'b0010;
    set_req(1, 32'h0000_0200, 32'h0000_0200, 1);
    step("r1carry");
    chk("r1carry.sum_const", 64'(rsp_sum), 64'h400);
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    step("r1ovf");
    chk("r1ovf.sum_const", 64'(rsp_sum), 64'h1_FFFF_FFFE);
    req_valid = '0;
    step("idle");

    // All requesters streaming: rotation with no bubbles
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 1000 + 7), 32'(i * 333 + 1), i[0]);
    req_valid = '1;
    m_ptr = m_ptr; // rotation starts from wherever the pointer was left
    for (int i = 0; i < 5; i++) step("stream");
    req_valid = '0;
    step("drain");

    // Backpressure then release: req2 accepted the cycle rsp_ready rises
    req_valid = 4'b0001;
    step("prefill");
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    set_req(2, 32'h1234_5678, 32'h0FED_CBA9, 1);
    for (int i = 0; i < 3; i++) step("bp");
    rsp_ready = 1'b1;
    step("bprelease");
    chk("bprelease.id_const", 64'(rsp_id), 64'd2);
    req_valid = '0;
    step("idle2");

    // Pointer at 2 with only req0 and req3 pending: req3 first, then req0
    req_valid = 4'b0010;
    step("toptr2");
    req_valid = 4'b1001;
    step("wrap_a");
    chk("wrap_a.id_const", 64'(rsp_id), 64'd3);
    step("wrap_b");
    chk("wrap_b.id_const", 64'(rsp_id), 64'd0);
    req_valid = '0;

    // Asynchronous reset with a pending result
    step("preRst");
    req_valid = 4'b0100;
    step("preRst2");
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1 chk("arst.valid", 64'(rsp_valid), 64'd0);
    chk("arst.sum", 64'(rsp_sum), 64'd0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b0011;
    set_req(0, 32'd5, 32'd6, 0);
    set_req(1, 32'd7, 32'd8, 0);
    step("postRst");
    chk("postRst.id_const", 64'(rsp_id), 64'd0);
    req_valid = 4'b0010;
    step("postRst1");

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                $urandom, $urandom_range(0, 1) == 1);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
